ott_ram_arb: RTL and testbench

OTT_RAM_ARB -- requirements
Module: ott_ram_arb

---
 rtl/ott_ram_arb_pkg.sv | 23 ++
 rtl/ott_rd_tag_pipe.sv | 69 ++++++
 rtl/ott_ram_arb.sv | 148 ++++++++++++++
 tb/tb_ott_ram_arb.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ott_ram_arb_pkg.sv
// Shared definitions for the OTT RAM read-port arbiter: FSM states, return
// source tags and parameter defaults.
package ott_ram_arb_pkg;

    localparam int unsigned ADDR_W_DEF  = 10;
    localparam int unsigned RAM_LAT_DEF = 2;

    // Source tag carried alongside each RAM read so returning data can be routed.
    localparam logic SRC_DMA = 1'b0;
    localparam logic SRC_LK  = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DMA_RD = 2'd1,
        LK_RD  = 2'd2
    } arb_state_t;

    // Burst length field: 0 encodes a full 16-word burst.
    function automatic logic [4:0] burst_words(input logic [4:0] len);
        return (len == 5'd0) ? 5'd16 : len;
    endfunction

endpackage

// File: rtl/ott_rd_tag_pipe.sv
// Tag/data return pipeline: tracks each RAM read (valid + source) for RAM_LAT
// cycles and steers the returning word to the DMA or lookup output register.
module ott_rd_tag_pipe
    import ott_ram_arb_pkg::*;
#(
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned RAM_LAT = RAM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue,
    input  logic              issue_src,
    input  logic [DATA_W-1:0] ram_data,
    output logic              dma_vld,
    output logic [DATA_W-1:0] dma_data,
    output logic              lk_vld,
    output logic [DATA_W-1:0] lk_data
);

    logic [RAM_LAT-1:0] vld_q;
    logic [RAM_LAT-1:0] src_q;
    logic [RAM_LAT:0]   vld_chain;
    logic [RAM_LAT:0]   src_chain;
    logic [DATA_W-1:0]  dma_data_q;
    logic [DATA_W-1:0]  lk_data_q;
    logic               cap_vld;
    logic               cap_src;

    // Chain bit 0 is the read issued this cycle; bit RAM_LAT is the word being presented.
    assign vld_chain = {vld_q, issue};
    assign src_chain = {src_q, issue_src};
    // The stage just before the output is the one whose data sits on the RAM bus now.
    assign cap_vld   = vld_chain[RAM_LAT-1];
    assign cap_src   = src_chain[RAM_LAT-1];

    // Shift the tag pipeline; reset drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            src_q <= '0;
        end else begin
            vld_q <= vld_chain[RAM_LAT-1:0];
            src_q <= src_chain[RAM_LAT-1:0];
        end
    end

    // Capture RAM data into the register owned by the word's source; hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_data_q <= '0;
            lk_data_q  <= '0;
        end else if (cap_vld) begin
            if (cap_src == SRC_DMA) begin
                dma_data_q <= ram_data;
            end else begin
                lk_data_q <= ram_data;
            end
        end
    end

    // Valid strobes come straight from the last tag stage, aligned with the data registers.
    always_comb begin
        dma_vld  = vld_chain[RAM_LAT] && (src_chain[RAM_LAT] == SRC_DMA);
        lk_vld   = vld_chain[RAM_LAT] && (src_chain[RAM_LAT] == SRC_LK);
        dma_data = dma_data_q;
        lk_data  = lk_data_q;
    end

endmodule

// File: rtl/ott_ram_arb.sv
// OTT RAM read-port arbiter: shares one RAM read port between DMA bursts and
// single-word lookups, with a lookup slot forced after each DMA read while a
// lookup is waiting.
module ott_ram_arb
    import ott_ram_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = ADDR_W_DEF,
    parameter int unsigned DATA_W  = 64,
    parameter int unsigned RAM_LAT = RAM_LAT_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              dma_raddr_en,
    input  logic [31:0]       dma_raddr,
    input  logic [4:0]        dma_rlen,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rdata_rdy,
    output logic              dma_rdata_busy,
    input  logic              lk_req,
    input  logic [ADDR_W-1:0] lk_addr,
    output logic              lk_ack,
    output logic [DATA_W-1:0] lk_rdata,
    output logic              lk_rdata_vld,
    output logic              ott_ram_rd_en,
    output logic [ADDR_W-1:0] ott_ram_addr,
    input  logic [DATA_W-1:0] ott_ram_data
);

    arb_state_t        state_q;
    arb_state_t        state_d;
    logic [ADDR_W-1:0] dma_addr_q;
    logic [4:0]        dma_cnt_q;   // words still to issue
    logic [4:0]        ret_cnt_q;   // words still to return
    logic              dma_pend_q;  // burst accepted while a lookup took the first slot
    logic              busy_q;
    logic              accept;
    logic              dma_issue;
    logic              lk_issue;
    logic              last_issue;
    logic              unused_raddr_hi;

    assign unused_raddr_hi = ^dma_raddr[31:ADDR_W];

    assign accept     = (state_q == IDLE) && dma_raddr_en && !busy_q;
    assign dma_issue  = (state_q == DMA_RD);
    assign lk_issue   = (state_q == LK_RD);
    assign last_issue = dma_issue && (dma_cnt_q == 5'd1);

    // Next-state: lookups win in IDLE and get the slot after any DMA read they waited on.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (lk_req) begin
                    state_d = LK_RD;
                end else if (accept) begin
                    state_d = DMA_RD;
                end
            end
            DMA_RD: begin
                if (lk_req) begin
                    state_d = LK_RD;
                end else if (last_issue) begin
                    state_d = IDLE;
                end
            end
            LK_RD: begin
                state_d = (dma_pend_q || (dma_cnt_q != 5'd0)) ? DMA_RD : IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Burst address and issue counter; address wraps naturally at 2^ADDR_W.
    always_ff @(posedge clk) begin
        if (rst) begin
            dma_addr_q <= '0;
            dma_cnt_q  <= '0;
            dma_pend_q <= 1'b0;
        end else begin
            if (accept) begin
                dma_addr_q <= dma_raddr[ADDR_W-1:0];
                dma_cnt_q  <= burst_words(dma_rlen);
                dma_pend_q <= lk_req;
            end else if (dma_issue) begin
                dma_addr_q <= dma_addr_q + 1'b1;
                dma_cnt_q  <= dma_cnt_q - 5'd1;
            end
            if (lk_issue) begin
                dma_pend_q <= 1'b0;
            end
        end
    end

    // Busy spans acceptance through the cycle of the burst's last returned word.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q    <= 1'b0;
            ret_cnt_q <= '0;
        end else if (accept) begin
            busy_q    <= 1'b1;
            ret_cnt_q <= burst_words(dma_rlen);
        end else if (dma_rdata_rdy) begin
            ret_cnt_q <= ret_cnt_q - 5'd1;
            if (ret_cnt_q == 5'd1) begin
                busy_q <= 1'b0;
            end
        end
    end

    // RAM port and handshake outputs decoded from the current state.
    always_comb begin
        ott_ram_rd_en  = dma_issue || lk_issue;
        ott_ram_addr   = '0;
        if (dma_issue) begin
            ott_ram_addr = dma_addr_q;
        end else if (lk_issue) begin
            ott_ram_addr = lk_addr;
        end
        lk_ack         = lk_issue;
        dma_rdata_busy = busy_q;
    end

    ott_rd_tag_pipe #(
        .DATA_W  (DATA_W),
        .RAM_LAT (RAM_LAT)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .issue     (ott_ram_rd_en),
        .issue_src (lk_issue ? SRC_LK : SRC_DMA),
        .ram_data  (ott_ram_data),
        .dma_vld   (dma_rdata_rdy),
        .dma_data  (dma_rdata),
        .lk_vld    (lk_rdata_vld),
        .lk_data   (lk_rdata)
    );

endmodule

// File: tb/tb_ott_ram_arb.sv
// Bench for ott_ram_arb: directed scenarios plus randomized traffic, checked
// every cycle against a slot-ownership model of the RAM port.
module tb_ott_ram_arb;

    localparam int AW  = 10;
    localparam int DW  = 64;
    localparam int LAT = 2;

    localparam int O_NONE = 0;
    localparam int O_DMA  = 1;
    localparam int O_LK   = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          dma_raddr_en;
    logic [31:0]   dma_raddr;
    logic [4:0]    dma_rlen;
    logic [DW-1:0] dma_rdata;
    logic          dma_rdata_rdy;
    logic          dma_rdata_busy;
    logic          lk_req;
    logic [AW-1:0] lk_addr;
    logic          lk_ack;
    logic [DW-1:0] lk_rdata;
    logic          lk_rdata_vld;
    logic          ott_ram_rd_en;
    logic [AW-1:0] ott_ram_addr;
    logic [DW-1:0] ott_ram_data;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Model: who owns the RAM port this cycle, plus burst bookkeeping.
    int            m_owner;
    int            m_left;
    logic [AW-1:0] m_addr;
    logic          m_busy;
    int            m_ret;
    logic          ring_vld  [4];
    logic          ring_lk   [4];
    logic [DW-1:0] ring_data [4];
    logic [DW-1:0] exp_dma;
    logic [DW-1:0] exp_lk;

    // Observations taken from the DUT for scenario-level constant checks.
    int            n_dma_seen;
    int            n_lk_seen;
    int            n_issue;
    logic [31:0]   issue_bits;
    logic [AW-1:0] dma_trace [$];

    always #5 clk = ~clk;

    ott_ram_arb #(
        .ADDR_W  (AW),
        .DATA_W  (DW),
        .RAM_LAT (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .dma_raddr_en   (dma_raddr_en),
        .dma_raddr      (dma_raddr),
        .dma_rlen       (dma_rlen),
        .dma_rdata      (dma_rdata),
        .dma_rdata_rdy  (dma_rdata_rdy),
        .dma_rdata_busy (dma_rdata_busy),
        .lk_req         (lk_req),
        .lk_addr        (lk_addr),
        .lk_ack         (lk_ack),
        .lk_rdata       (lk_rdata),
        .lk_rdata_vld   (lk_rdata_vld),
        .ott_ram_rd_en  (ott_ram_rd_en),
        .ott_ram_addr   (ott_ram_addr),
        .ott_ram_data   (ott_ram_data)
    );

    function automatic logic [DW-1:0] ram_word(input logic [AW-1:0] a);
        return {a, 22'h2AAAAA, ~a, 22'h155555};
    endfunction

    // RAM with one output register: the word read in cycle t is on the bus in
    // cycle t+1 and is sampled by the arbiter at the LAT-th edge after the read.
    // Between reads the bus carries junk.
    always @(posedge clk) begin
        if (ott_ram_rd_en) begin
            ott_ram_data <= ram_word(ott_ram_addr);
        end else begin
            ott_ram_data <= {$urandom, $urandom};
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_owner = O_NONE;
        m_left  = 0;
        m_addr  = '0;
        m_busy  = 1'b0;
        m_ret   = 0;
        exp_dma = '0;
        exp_lk  = '0;
        for (int i = 0; i < 4; i++) begin
            ring_vld[i]  = 1'b0;
            ring_lk[i]   = 1'b0;
            ring_data[i] = '0;
        end
    endtask

    task automatic clear_obs();
        n_dma_seen = 0;
        n_lk_seen  = 0;
        n_issue    = 0;
        issue_bits = '0;
        dma_trace.delete();
    endtask

    function automatic logic ring_any();
        logic r = 1'b0;
        for (int i = 0; i < 4; i++) r |= ring_vld[i];
        return r;
    endfunction

    task automatic schedule(input logic is_lk, input logic [DW-1:0] d);
        int s;
        s = (cyc + LAT) % 4;
        ring_vld[s]  = 1'b1;
        ring_lk[s]   = is_lk;
        ring_data[s] = d;
    endtask

    task automatic check_quiet(input string pfx);
        check_eq({pfx, "_rd_en"}, 64'(ott_ram_rd_en), 64'd0);
        check_eq({pfx, "_addr"},  64'(ott_ram_addr), 64'd0);
        check_eq({pfx, "_ack"},   64'(lk_ack), 64'd0);
        check_eq({pfx, "_rdy"},   64'(dma_rdata_rdy), 64'd0);
        check_eq({pfx, "_vld"},   64'(lk_rdata_vld), 64'd0);
        check_eq({pfx, "_busy"},  64'(dma_rdata_busy), 64'd0);
        check_eq({pfx, "_dmad"},  dma_rdata, 64'd0);
        check_eq({pfx, "_lkd"},   lk_rdata, 64'd0);
    endtask

    // Check the current cycle against the model, then advance one clock using
    // the inputs the caller has applied for this cycle.
    task automatic tick();
        int            slot;
        int            cur;
        logic          exp_rdy;
        logic          exp_vld;
        logic          ack_seen;
        logic          accept;
        logic [AW-1:0] exp_addr;

        slot    = cyc % 4;
        exp_rdy = ring_vld[slot] && !ring_lk[slot];
        exp_vld = ring_vld[slot] && ring_lk[slot];
        if (exp_rdy) exp_dma = ring_data[slot];
        if (exp_vld) exp_lk = ring_data[slot];
        ring_vld[slot] = 1'b0;
        exp_addr = (m_owner == O_DMA) ? m_addr : (m_owner == O_LK) ? lk_addr : '0;

        check_eq("rd_en",     64'(ott_ram_rd_en), 64'(m_owner != O_NONE));
        check_eq("ram_addr",  64'(ott_ram_addr), 64'(exp_addr));
        check_eq("lk_ack",    64'(lk_ack), 64'(m_owner == O_LK));
        check_eq("dma_rdy",   64'(dma_rdata_rdy), 64'(exp_rdy));
        check_eq("lk_vld",    64'(lk_rdata_vld), 64'(exp_vld));
        check_eq("dma_rdata", dma_rdata, exp_dma);
        check_eq("lk_rdata",  lk_rdata, exp_lk);
        check_eq("busy",      64'(dma_rdata_busy), 64'(m_busy));

        if (dma_rdata_rdy) n_dma_seen++;
        if (lk_rdata_vld) n_lk_seen++;
        if (ott_ram_rd_en) begin
            n_issue++;
            issue_bits = {issue_bits[30:0], lk_ack};
            if (!lk_ack) dma_trace.push_back(ott_ram_addr);
        end
        ack_seen = lk_ack;

        if (rst) begin
            model_reset();
        end else begin
            cur    = m_owner;
            accept = (cur == O_NONE) && dma_raddr_en && !m_busy;
            if (exp_rdy) begin
                m_ret--;
                if (m_ret == 0) m_busy = 1'b0;
            end
            if (cur == O_DMA) begin
                schedule(1'b0, ram_word(m_addr));
                m_addr++;
                m_left--;
            end else if (cur == O_LK) begin
                schedule(1'b1, ram_word(lk_addr));
            end
            if (accept) begin
                m_addr = dma_raddr[AW-1:0];
                m_left = (dma_rlen == 5'd0) ? 16 : int'(dma_rlen);
                m_ret  = m_left;
                m_busy = 1'b1;
            end
            // A waiting lookup takes the next slot unless it was just served.
            if (cur != O_LK && lk_req) m_owner = O_LK;
            else if (m_left > 0) m_owner = O_DMA;
            else m_owner = O_NONE;
        end

        @(posedge clk);
        #1;
        cyc++;
        if (ack_seen) lk_req = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((m_busy || dma_rdata_busy || m_owner != O_NONE || lk_req || ring_any())
               && n < 200) begin
            tick();
            n++;
        end
        check_eq("idle_wait_in_budget", 64'(n < 200), 64'd1);
    endtask

    task automatic start_burst(input logic [31:0] a, input logic [4:0] len);
        dma_raddr    = a;
        dma_rlen     = len;
        dma_raddr_en = 1'b1;
        tick();
        dma_raddr_en = 1'b0;
    endtask

    initial begin
        rst          = 1'b1;
        dma_raddr_en = 1'b0;
        dma_raddr    = '0;
        dma_rlen     = '0;
        lk_req       = 1'b0;
        lk_addr      = '0;
        model_reset();
        clear_obs();
        repeat (3) @(posedge clk);
        #1;
        check_quiet("reset");
        rst = 1'b0;
        repeat (2) tick();

        // Plain 4-word burst.
        clear_obs();
        start_burst(32'h10, 5'd4);
        wait_idle();
        check_eq("s1_words", 64'(n_dma_seen), 64'd4);
        check_eq("s1_reads", 64'(dma_trace.size()), 64'd4);
        for (int i = 0; i < 4; i++) check_eq("s1_addr", 64'(dma_trace[i]), 64'(16 + i));

        // Lookup raised during the 3rd read of an 8-word burst.
        clear_obs();
        start_burst(32'h100, 5'd8);
        tick();
        tick();
        lk_req  = 1'b1;
        lk_addr = 10'h2A5;
        wait_idle();
        check_eq("s2_issues", 64'(n_issue), 64'd9);
        check_eq("s2_order", 64'(issue_bits), 64'h20);
        check_eq("s2_dma_words", 64'(n_dma_seen), 64'd8);
        check_eq("s2_lk_words", 64'(n_lk_seen), 64'd1);
        check_eq("s2_lk_data", lk_rdata, ram_word(10'h2A5));

        // Collision in IDLE: lookup first, then the burst.
        clear_obs();
        lk_req  = 1'b1;
        lk_addr = 10'h055;
        start_burst(32'h20, 5'd3);
        wait_idle();
        check_eq("s3_issues", 64'(n_issue), 64'd4);
        check_eq("s3_order", 64'(issue_bits), 64'h8);

        // Length 0 means 16, with address wrap; upper address bits ignored.
        clear_obs();
        start_burst(32'hABCD_03FE, 5'd0);
        wait_idle();
        check_eq("s4_reads", 64'(dma_trace.size()), 64'd16);
        check_eq("s4_a0", 64'(dma_trace[0]), 64'h3FE);
        check_eq("s4_a1", 64'(dma_trace[1]), 64'h3FF);
        check_eq("s4_a2", 64'(dma_trace[2]), 64'h000);
        check_eq("s4_a15", 64'(dma_trace[15]), 64'h00D);
        check_eq("s4_words", 64'(n_dma_seen), 64'd16);

        // Reset during the 5th read of a 16-word burst.
        clear_obs();
        start_burst(32'h40, 5'd0);
        repeat (4) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_quiet("s5_after_rst");
        repeat (6) tick();
        check_eq("s5_issues", 64'(n_issue), 64'd5);
        check_eq("s5_words", 64'(n_dma_seen), 64'd3);
        clear_obs();
        start_burst(32'h80, 5'd5);
        wait_idle();
        check_eq("s5_new_words", 64'(n_dma_seen), 64'd5);
        check_eq("s5_new_last", 64'(dma_trace[4]), 64'h84);

        // Requests during a burst and during its data tail are ignored.
        clear_obs();
        start_burst(32'h200, 5'd6);
        repeat (2) tick();
        start_burst(32'h300, 5'd2);
        repeat (3) tick();
        start_burst(32'h310, 5'd2);
        wait_idle();
        check_eq("s6_reads", 64'(dma_trace.size()), 64'd6);
        check_eq("s6_last", 64'(dma_trace[5]), 64'h205);
        check_eq("s6_words", 64'(n_dma_seen), 64'd6);

        // Randomized traffic.
        for (int ep = 0; ep < 60; ep++) begin
            if (!lk_req && $urandom_range(0, 3) == 0) begin
                lk_req  = 1'b1;
                lk_addr = AW'($urandom);
            end
            start_burst($urandom, 5'($urandom_range(0, 16)));
            repeat ($urandom_range(4, 30)) begin
                if (!lk_req && $urandom_range(0, 2) == 0) begin
                    lk_req  = 1'b1;
                    lk_addr = AW'($urandom);
                end
                if ($urandom_range(0, 9) == 0) begin
                    dma_raddr_en = 1'b1;
                    dma_raddr    = $urandom;
                    dma_rlen     = 5'($urandom_range(0, 16));
                end
                if ($urandom_range(0, 49) == 0) rst = 1'b1;
                tick();
                dma_raddr_en = 1'b0;
                rst          = 1'b0;
            end
            wait_idle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
